fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 Parameter TIMEOUT_CYC, default 16, fetch-acknowledge timeout in cycles (used only with FETCH_TIMEOUT_EN).
REQ-004 Ports: clk input 1, single clock, all logic on rising edge.
REQ-005 Ports: rst input 1, synchronous, active-high reset.
REQ-006 Ports: run input 1, level; 1 permits fetching, 0 parks the block in IDLE.
REQ-007 Ports: rom_req output 1, fetch request to program memory.
REQ-008 Ports: rom_addr output ADDR_W, fetch address, equals PC.
REQ-009 Ports: rom_ack input 1, memory returns data; honored only while rom_req=1.
REQ-010 Ports: rom_data input 9, instruction word, sampled when rom_ack=1.
REQ-011 Ports: i_instruccion output 9, instruction presented to the decoder.
REQ-012 Ports: instr_valid output 1, i_instruccion is valid for the decoder this cycle.
REQ-013 Ports: condJ input 4, decoder jump control; bit3=1 means jump instruction, bits2:0 select condition.
REQ-014 Ports: flag_z, flag_c, flag_n inputs 1 each, ALU zero/carry/negative flags.
REQ-015 Ports: jump_target input ADDR_W, target address from register bus.
REQ-016 Ports: pc_link output ADDR_W, return address (PC+1) for the R7 write-back path.
REQ-017 Ports: fetch_err output 1, sticky timeout error flag.

Function
REQ-018 States: IDLE, FETCH, ISSUE, RESOLVE; one transition per clock at most.
REQ-019 IDLE: rom_req=0; go to FETCH when run=1.
REQ-020 FETCH: rom_req=1, rom_addr=PC; on rom_ack=1 latch rom_data into i_instruccion, go to ISSUE; ack in any other state is ignored.
REQ-021 ISSUE: instr_valid=1 for exactly one cycle; pc_link registered as PC+1 modulo 2^ADDR_W; go to RESOLVE.
REQ-022 RESOLVE: sample condJ and flags; taken when condJ[3]=1 and condition holds: 001 always, 010 Z=1, 011 Z=0, 100 C=1, 101 C=0, 110 N=1, 111 N=0, 000 never.
REQ-023 RESOLVE: PC becomes jump_target if taken, else PC+1 modulo 2^ADDR_W (ADDR_W all-ones wraps to 0).
REQ-024 RESOLVE: go to FETCH if run=1, else IDLE; run falling mid-instruction completes the current instruction first.
REQ-025 Fetch-to-issue latency: instr_valid asserts the cycle after the rom_ack edge; minimum 3 cycles per instruction.
REQ-026 i_instruccion holds its value outside ISSUE; decoder outputs remain stable through RESOLVE.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, PC=RESET_PC, rom_req=0, rom_addr=RESET_PC, i_instruccion=9'b111000000 (NOP), instr_valid=0, pc_link=0, fetch_err=0, timeout counter=0.
REQ-028 rst mid-FETCH drops rom_req on the same edge; a rom_ack arriving with or after reset is discarded.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: counter runs in FETCH; after TIMEOUT_CYC cycles without rom_ack, set fetch_err=1, drop rom_req, enter IDLE and stay there, ignoring run, until rst.
REQ-030 Macro FETCH_TIMEOUT_EN undefined: no counter, fetch_err tied 0, FETCH waits for rom_ack indefinitely.

Verification
REQ-031 Reset, run=1, ack data 9'b000001010 at addr 0 after 1 cycle -> instr_valid one cycle with that word, pc_link=1, next rom_addr=1.
REQ-032 PC=5, condJ=4'b1010, flag_z=1, jump_target=8'h40 -> next rom_addr=8'h40; same with flag_z=0 -> rom_addr=6.
REQ-033 PC=8'hFF, condJ=4'b0001 -> next rom_addr=8'h00, pc_link=8'h00.
REQ-034 run cleared during ISSUE -> RESOLVE completes, PC advances, rom_req stays 0; run=1 again -> fetch resumes at new PC.
REQ-035 FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, rom_req=0, stays IDLE until rst clears it.
REQ-036 rst asserted while rom_req=1, ack on same edge -> i_instruccion=NOP, PC=RESET_PC, instr_valid never asserted.

Source files
------------

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE -> FETCH -> ISSUE -> RESOLVE, with conditional jump resolution.
// Define FETCH_TIMEOUT_EN to enable the sticky fetch-acknowledge timeout (fetch_err).
module fetch_seq #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [8:0]        rom_data,
    output logic [8:0]        i_instruccion,
    output logic              instr_valid,
    input  logic [3:0]        condJ,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_n,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_link,
    output logic              fetch_err
);

    localparam logic [8:0] Nop = 9'b111000000;

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StResolve} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [8:0]        instr_q;
    logic [ADDR_W-1:0] link_q;
    logic              cond_ok;
    logic              taken;
    logic              timeout;
    logic              err;

    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout = (state_q == StFetch) && !rom_ack && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StFetch && !rom_ack) cnt_q <= cnt_q + CntW'(1);
            else                                cnt_q <= '0;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    always_comb begin
        cond_ok = 1'b0;
        unique case (condJ[2:0])
            3'b001:  cond_ok = 1'b1;
            3'b010:  cond_ok = flag_z;
            3'b011:  cond_ok = !flag_z;
            3'b100:  cond_ok = flag_c;
            3'b101:  cond_ok = !flag_c;
            3'b110:  cond_ok = flag_n;
            3'b111:  cond_ok = !flag_n;
            default: cond_ok = 1'b0;
        endcase
    end

    assign taken = condJ[3] && cond_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; a latched error parks the block in IDLE until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (run && !err) state_d = StFetch;
            StFetch: begin
                if (timeout)      state_d = StIdle;
                else if (rom_ack) state_d = StIssue;
            end
            StIssue:   state_d = StResolve;
            StResolve: state_d = run ? StFetch : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        rom_req     = (state_q == StFetch);
        instr_valid = (state_q == StIssue);
    end

    // Datapath: reset takes priority, so an ack coinciding with rst is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= Nop;
            link_q  <= '0;
        end else begin
            if (state_q == StFetch && rom_ack) begin
                instr_q <= rom_data;
                link_q  <= pc_inc;
            end
            if (state_q == StResolve) pc_q <= taken ? jump_target : pc_inc;
        end
    end

    assign rom_addr      = pc_q;
    assign i_instruccion = instr_q;
    assign pc_link       = link_q;
    assign fetch_err     = err;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: scoreboard of issued words plus PC/jump model.
// Covers the FETCH_TIMEOUT_EN build and the default build.
module tb_fetch_seq;

    localparam logic [8:0] NOP = 9'b111000000;

    logic       clk = 1'b0;
    logic       rst, run, rom_ack;
    logic [8:0] rom_data;
    logic [3:0] condJ;
    logic       flag_z, flag_c, flag_n;
    logic [7:0] jump_target;
    logic       rom_req, instr_valid, fetch_err;
    logic [7:0] rom_addr, pc_link;
    logic [8:0] i_instruccion;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_pc;

    typedef struct {
        logic [8:0] word;
        logic [7:0] link;
    } exp_t;
    exp_t sb[$];

    fetch_seq dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .i_instruccion(i_instruccion),
        .instr_valid  (instr_valid),
        .condJ        (condJ),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_n       (flag_n),
        .jump_target  (jump_target),
        .pc_link      (pc_link),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic cond_taken(input logic [3:0] cj, input logic z, c, n);
        logic t;
        case (cj[2:0])
            3'b001:  t = 1'b1;
            3'b010:  t = z;
            3'b011:  t = ~z;
            3'b100:  t = c;
            3'b101:  t = ~c;
            3'b110:  t = n;
            3'b111:  t = ~n;
            default: t = 1'b0;
        endcase
        return cj[3] & t;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rom_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One full instruction: ack after 'delay' extra FETCH cycles, then ISSUE and RESOLVE.
    task automatic fetch_one(input logic [8:0] word, input int delay, input logic [3:0] cj,
                             input logic z, input logic c, input logic n,
                             input logic [7:0] tgt, input logic run_after);
        bit   ok;
        exp_t e;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fetch_req: rom_req=%b, required 1 within 20 cycles", rom_req);
            return;
        end
        n_checks++;
        if (rom_addr !== model_pc) begin
            n_fail++;
            $display("FAIL fetch_addr: rom_addr=%h, required %h", rom_addr, model_pc);
        end
        repeat (delay) @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || rom_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_wait: instr_valid=%b rom_req=%b, required 0/1",
                     instr_valid, rom_req);
        end
        rom_ack     = 1'b1;
        rom_data    = word;
        condJ       = cj;
        flag_z      = z;
        flag_c      = c;
        flag_n      = n;
        jump_target = tgt;
        sb.push_back('{word: word, link: model_pc + 8'd1});
        @(negedge clk);
        rom_ack  = 1'b0;
        rom_data = 9'($urandom);
        run      = run_after;
        n_checks++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_valid: instr_valid=%b, required 1", instr_valid);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_sb: scoreboard empty at issue, required one entry");
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (i_instruccion !== e.word) begin
            n_fail++;
            $display("FAIL issue_word: i_instruccion=%b, required %b", i_instruccion, e.word);
        end
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || rom_req !== 1'b0) begin
            n_fail++;
            $display("FAIL resolve_ctl: instr_valid=%b rom_req=%b, required 0/0",
                     instr_valid, rom_req);
        end
        n_checks++;
        if (pc_link !== e.link) begin
            n_fail++;
            $display("FAIL pc_link: pc_link=%h, required %h", pc_link, e.link);
        end
        model_pc = cond_taken(cj, z, c, n) ? tgt : model_pc + 8'd1;
        @(negedge clk);
        condJ       = 4'($urandom);
        jump_target = 8'($urandom);
        n_checks++;
        if (rom_addr !== model_pc || rom_req !== run_after) begin
            n_fail++;
            $display("FAIL next_pc: rom_addr=%h rom_req=%b, required %h/%b",
                     rom_addr, rom_req, model_pc, run_after);
        end
        n_checks++;
        if (i_instruccion !== e.word) begin
            n_fail++;
            $display("FAIL instr_hold: i_instruccion=%b, required %b", i_instruccion, e.word);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = '0;
        condJ = '0; flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0; jump_target = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rom_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: rom_req=%b instr_valid=%b fetch_err=%b, required 0/0/0",
                     rom_req, instr_valid, fetch_err);
        end
        n_checks++;
        if (rom_addr !== 8'h00 || pc_link !== 8'h00 || i_instruccion !== NOP) begin
            n_fail++;
            $display("FAIL reset_data: rom_addr=%h pc_link=%h instr=%b, required 00/00/%b",
                     rom_addr, pc_link, i_instruccion, NOP);
        end
        rst = 1'b0;
        model_pc = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rom_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_park: rom_req=%b with run=0, required 0", rom_req);
        end
    endtask

    task automatic test_basic();
        run = 1'b1;
        @(negedge clk);
        fetch_one(9'b000001010, 1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
    endtask

    task automatic test_branch();
        for (int i = 1; i < 5; i++)
            fetch_one(9'($urandom), i % 3, {1'b0, 3'($urandom)}, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
        fetch_one(9'h055, 0, 4'b1010, 1'b1, 1'b0, 1'b0, 8'h40, 1'b1);
        fetch_one(9'h0C3, 2, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);
        fetch_one(9'h1F0, 0, 4'b1010, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 24; i++)
            fetch_one(9'($urandom), i % 2, {1'b1, 3'(i)}, 1'($urandom), 1'($urandom),
                      1'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_wrap();
        fetch_one(9'h012, 0, 4'b1001, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
        fetch_one(9'h034, 0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1);
    endtask

    task automatic test_run_stop();
        fetch_one(9'h0A5, 1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rom_req !== 1'b0 || rom_addr !== model_pc) begin
            n_fail++;
            $display("FAIL run_stop: rom_req=%b rom_addr=%h, required 0/%h",
                     rom_req, rom_addr, model_pc);
        end
        run = 1'b1;
        fetch_one(9'h13C, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        bit seen = 1'b0;
        wait_req(ok);
        rst      = 1'b1;
        rom_ack  = 1'b1;
        rom_data = 9'h0AA;
        run      = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rom_req !== 1'b0 || rom_addr !== 8'h00 || i_instruccion !== NOP) begin
            n_fail++;
            $display("FAIL rst_fetch: rom_req=%b rom_addr=%h instr=%b, required 0/00/%b",
                     rom_req, rom_addr, i_instruccion, NOP);
        end
        rst     = 1'b0;
        rom_ack = 1'b0;
        model_pc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (instr_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_no_issue: instr_valid seen=1 after reset, required 0");
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt  = 0;
        bit bad  = 1'b0;
        run = 1'b1;
        wait_req(ok);
`ifdef FETCH_TIMEOUT_EN
        while (rom_req === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL timeout_len: rom_req high %0d cycles, required 16", cnt);
        end
        for (int i = 0; i < 6; i++) begin
            if (fetch_err !== 1'b1 || rom_req !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL timeout_park: fetch_err=%b rom_req=%b, required 1/0 held",
                     fetch_err, rom_req);
        end
`else
        for (int i = 0; i < 40; i++) begin
            if (fetch_err !== 1'b0 || rom_req !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || bad) begin
            n_fail++;
            $display("FAIL no_timeout: fetch_err=%b rom_req=%b, required 0/1 held",
                     fetch_err, rom_req);
        end
`endif
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fetch_err !== 1'b0 || rom_req !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: fetch_err=%b rom_req=%b, required 0/0",
                     fetch_err, rom_req);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_branch();
        test_wrap();
        test_run_stop();
        test_reset_mid_fetch();
        test_timeout();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
